fir_interp_mac: RTL and testbench

//  Image-rejection low-pass FIR that sits directly downstream of the zero-stuffing

---
 rtl/fir_interp_mac.sv | 122 ++++++++++++
 tb/tb_fir_interp_mac.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/fir_interp_mac.sv
// Image-rejection low-pass FIR behind the zero-stuffing upsampler: one shared
// multiply-accumulate stage stepping one tap per clock over a circular delay line.
module fir_interp_mac #(
  parameter int NTAPS = 8,
  parameter int CW    = 16,
  parameter int SHIFT = 15
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic signed [31:0]         d_in,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       coef_we,
  input  logic [$clog2(NTAPS)-1:0]   coef_addr,
  input  logic signed [CW-1:0]       coef_data,
  output logic signed [31:0]         d_out,
  output logic                       out_valid
);

  localparam int AW   = $clog2(NTAPS);
  // One extra coefficient bit so the reset value 1<<SHIFT stays positive (true identity).
  localparam int HW   = CW + 1;
  localparam int PW   = 32 + HW;
  localparam int ACCW = PW + AW;

  typedef enum logic [1:0] {IDLE = 2'd0, MAC = 2'd1, DONE = 2'd2} state_t;

  state_t                 state_r;
  logic signed [31:0]     x_r [NTAPS];
  logic signed [HW-1:0]   h_r [NTAPS];
  logic [AW-1:0]          wr_ptr_r;
  logic [AW-1:0]          k_r;
  logic signed [ACCW-1:0] acc_r;
  logic [AW-1:0]          rd_idx_s;
  logic signed [PW-1:0]   prod_s;
  logic                   accept_s;

  function automatic logic signed [31:0] sat32(input logic signed [ACCW-1:0] a);
    logic signed [ACCW-1:0] s;
    s = a >>> SHIFT;
    if ((&s[ACCW-1:31]) || (~|s[ACCW-1:31])) begin
      sat32 = $signed(s[31:0]);
    end else if (s[ACCW-1]) begin
      sat32 = 32'sh8000_0000;
    end else begin
      sat32 = 32'sh7FFF_FFFF;
    end
  endfunction

  // Tap product for the current k; the pointer difference wraps because NTAPS is a power of 2.
  always_comb begin
    rd_idx_s = wr_ptr_r - k_r;
    prod_s   = h_r[k_r] * x_r[rd_idx_s];
    accept_s = in_valid && in_ready && (state_r == IDLE);
  end

  // Coefficient bank, writable only while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NTAPS; i++) begin
        h_r[i] <= (i == 0) ? ({{(HW-1){1'b0}}, 1'b1} << SHIFT) : {HW{1'b0}};
      end
    end else if (coef_we && (state_r == IDLE)) begin
      h_r[coef_addr] <= {coef_data[CW-1], coef_data};
    end
  end

  // Circular sample delay line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NTAPS; i++) begin
        x_r[i] <= 32'sd0;
      end
    end else if (accept_s) begin
      x_r[wr_ptr_r] <= d_in;
    end
  end

  // Sequencer: accept, NTAPS accumulate cycles, then saturate and publish.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      wr_ptr_r  <= {AW{1'b0}};
      k_r       <= {AW{1'b0}};
      acc_r     <= {ACCW{1'b0}};
      d_out     <= 32'sd0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      out_valid <= 1'b0;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            acc_r    <= {ACCW{1'b0}};
            k_r      <= {AW{1'b0}};
            in_ready <= 1'b0;
            state_r  <= MAC;
          end
        end
        MAC: begin
          acc_r <= acc_r + {{AW{prod_s[PW-1]}}, prod_s};
          k_r   <= k_r + {{(AW-1){1'b0}}, 1'b1};
          if (k_r == AW'(NTAPS - 1)) begin
            wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            state_r  <= DONE;
          end
        end
        DONE: begin
          d_out     <= sat32(acc_r);
          out_valid <= 1'b1;
          in_ready  <= 1'b1;
          state_r   <= IDLE;
        end
        default: begin
          in_ready <= 1'b1;
          state_r  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_interp_mac.sv
// Self-checking bench for fir_interp_mac: directed vector table, handshake and reset
// corner sequences, then randomized traffic against a convolution reference model.
module tb_fir_interp_mac;
  localparam int NTAPS = 8;
  localparam int CW    = 16;
  localparam int SHIFT = 15;
  localparam int AW    = 3;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic signed [31:0]   d_in = 32'sd0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic                 coef_we = 1'b0;
  logic [AW-1:0]        coef_addr = 3'd0;
  logic signed [CW-1:0] coef_data = 16'sd0;
  logic signed [31:0]   d_out;
  logic                 out_valid;

  fir_interp_mac #(.NTAPS(NTAPS), .CW(CW), .SHIFT(SHIFT)) dut (
    .clk(clk), .rst(rst), .d_in(d_in), .in_valid(in_valid), .in_ready(in_ready),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .d_out(d_out), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference: y = clamp(floor(sum h[j]*x[j] / 2^SHIFT)), x[0] newest.
  longint h_m [NTAPS];
  longint x_m [NTAPS];

  typedef struct {
    int                 mode;   // 0 none, 1 reset (identity), 2 reset + all taps = cval
    logic signed [15:0] cval;
    logic signed [31:0] din;
    logic [31:0]        exp;
  } vec_t;
  vec_t vt[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] model_out();
    longint acc;
    longint sh;
    acc = 0;
    for (int j = 0; j < NTAPS; j++) acc += h_m[j] * x_m[j];
    sh = acc >>> SHIFT;
    if (sh > 64'sd2147483647) return 32'h7FFF_FFFF;
    if (sh < -64'sd2147483648) return 32'h8000_0000;
    return sh[31:0];
  endfunction

  task automatic model_reset();
    for (int j = 0; j < NTAPS; j++) begin
      h_m[j] = 0;
      x_m[j] = 0;
    end
    h_m[0] = 64'sd1 <<< SHIFT;
  endtask

  task automatic model_push(input logic signed [31:0] s);
    for (int j = NTAPS - 1; j > 0; j--) x_m[j] = x_m[j-1];
    x_m[0] = longint'(s);
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; coef_we = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    chk("rst_d_out", d_out, 32'h0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic write_coef(input int a, input logic signed [15:0] v);
    coef_we = 1'b1; coef_addr = AW'(a); coef_data = v;
    @(posedge clk); #1;
    coef_we = 1'b0;
    h_m[a] = longint'(v);
  endtask

  task automatic wait_ready();
    int t;
    t = 0;
    while (!in_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (!in_ready) chk("ready_timeout", {31'd0, in_ready}, 32'd1);
  endtask

  // Sends one sample (optionally with a same-cycle coef write, and a write while busy)
  // and checks value, latency and pulse width. use_model picks the model's expectation.
  task automatic send(input string nm, input logic signed [31:0] s,
                      input bit cw, input int ca, input logic signed [15:0] cd,
                      input bit busy, input int ba, input logic signed [15:0] bd,
                      input bit use_model, input logic [31:0] exp_in);
    logic [31:0] got;
    logic [31:0] exp;
    int lat;
    wait_ready();
    d_in = s; in_valid = 1'b1;
    if (cw) begin coef_we = 1'b1; coef_addr = AW'(ca); coef_data = cd; end
    @(posedge clk); #1;
    in_valid = 1'b0; coef_we = 1'b0;
    if (cw) h_m[ca] = longint'(cd);
    model_push(s);
    exp = use_model ? model_out() : exp_in;
    got = 'x;
    lat = 0;
    while (lat < 20) begin
      if (busy && lat == 2) begin
        coef_we = 1'b1; coef_addr = AW'(ba); coef_data = bd;
      end else begin
        coef_we = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
      if (out_valid) break;
    end
    coef_we = 1'b0;
    got = out_valid ? d_out : 'x;
    chk({nm, "_val"}, got, exp);
    chk({nm, "_lat"}, lat, NTAPS + 1);
    @(posedge clk); #1;
    chk({nm, "_pulse"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    logic [31:0] outs[$];
    int acc_cyc[$];
    logic [31:0] nxt;
    bit rdy, vld, saw;

    // Directed vectors: identity, moving average, saturation both signs.
    vt.push_back('{1, 16'sd0, 32'sd100, 32'd100});
    vt.push_back('{0, 16'sd0, -32'sd7, 32'hFFFF_FFF9});
    vt.push_back('{2, 16'sd4096, 32'sd8000, 32'd1000});
    for (int i = 0; i < 7; i++) vt.push_back('{0, 16'sd0, 32'sd0, 32'd1000});
    vt.push_back('{0, 16'sd0, 32'sd0, 32'd0});
    vt.push_back('{2, 16'sd32767, 32'sh7FFF_FFFF, 32'd2147418111});
    for (int i = 0; i < 7; i++) vt.push_back('{0, 16'sd0, 32'sh7FFF_FFFF, 32'h7FFF_FFFF});
    vt.push_back('{2, 16'sd32767, 32'sh8000_0000, 32'h8001_0000});
    for (int i = 0; i < 7; i++) vt.push_back('{0, 16'sd0, 32'sh8000_0000, 32'h8000_0000});

    model_reset();
    #2;
    do_reset();
    foreach (vt[i]) begin
      if (vt[i].mode >= 1) do_reset();
      if (vt[i].mode == 2) for (int k = 0; k < NTAPS; k++) write_coef(k, vt[i].cval);
      send($sformatf("vec%0d", i), vt[i].din, 1'b0, 0, 16'sd0, 1'b0, 0, 16'sd0, 1'b0, vt[i].exp);
    end

    // Handshake: in_valid held high, accepts spaced NTAPS+2 apart, nothing lost.
    do_reset();
    nxt = 32'd1000;
    for (int c = 0; c < 48; c++) begin
      rdy = in_ready;
      vld = (c < 40);
      in_valid = vld; d_in = nxt;
      @(posedge clk); #1;
      if (vld && rdy) begin acc_cyc.push_back(c); nxt++; end
      if (out_valid) outs.push_back(d_out);
    end
    in_valid = 1'b0;
    chk("hs_accepts", acc_cyc.size(), 32'd4);
    chk("hs_outputs", outs.size(), 32'd4);
    foreach (acc_cyc[i]) chk($sformatf("hs_acc_cyc%0d", i), acc_cyc[i], (NTAPS + 2) * i);
    foreach (outs[i]) chk($sformatf("hs_out%0d", i), outs[i], 32'd1000 + i);

    // Reset during MAC: no pulse, d_out cleared, identity restored.
    do_reset();
    write_coef(1, 16'sd12345);
    send("pre_rst", 32'sd123, 1'b0, 0, 16'sd0, 1'b0, 0, 16'sd0, 1'b1, 32'd0);
    wait_ready();
    d_in = 32'sd77; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    chk("midrst_d_out", d_out, 32'h0);
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    saw = 1'b0;
    repeat (NTAPS + 3) begin
      @(posedge clk); #1;
      if (out_valid) saw = 1'b1;
    end
    chk("midrst_no_pulse", {31'd0, saw}, 32'd0);
    send("post_rst", 32'sd55, 1'b0, 0, 16'sd0, 1'b0, 0, 16'sd0, 1'b0, 32'd55);

    // Coefficient write while busy is dropped.
    do_reset();
    send("busy_we", 32'sd42, 1'b0, 0, 16'sd0, 1'b1, 0, 16'sd0, 1'b0, 32'd42);
    send("busy_we_after", -32'sd42, 1'b0, 0, 16'sd0, 1'b0, 0, 16'sd0, 1'b0, 32'hFFFF_FFD6);

    // Randomized traffic with the reference model.
    do_reset();
    for (int n = 0; n < 60; n++) begin
      logic signed [31:0] s;
      if ($urandom_range(3, 0) == 0) write_coef($urandom_range(NTAPS - 1, 0), 16'($urandom));
      s = ($urandom_range(3, 0) == 0) ? 32'sd0 : 32'($urandom);
      send($sformatf("rnd%0d", n), s, ($urandom_range(2, 0) == 0),
           $urandom_range(NTAPS - 1, 0), 16'($urandom),
           ($urandom_range(1, 0) == 1), $urandom_range(NTAPS - 1, 0), 16'($urandom),
           1'b1, 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
